// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - decode-side signals between the controller and hazard_unit
interface hazard_unit_if #(
    parameter int FW = 2
);
    logic          dec_valid;
    logic [4:0]    dec_rs1;
    logic [4:0]    dec_rs2;
    logic          dec_uses_rs1;
    logic          dec_uses_rs2;
    logic [4:0]    dec_rd;
    logic          dec_rf_we;
    logic          dec_is_load;
    logic          redirect;
    logic          stall;
    logic          inst_kill;
    logic [FW-1:0] fwd_a;
    logic [FW-1:0] fwd_b;

    modport master (
        output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
               dec_rd, dec_rf_we, dec_is_load, redirect,
        input  stall, inst_kill, fwd_a, fwd_b
    );

    modport slave (
        input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
               dec_rd, dec_rf_we, dec_is_load, redirect,
        output stall, inst_kill, fwd_a, fwd_b
    );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - pipeline hazard controller: forwarding selects, load-use stall, branch kill
// Optional HAZARD_PERF_EN adds stall_count/kill_count cycle counters.
module hazard_unit #(
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int BR_KILL    = 1,
    parameter int FW         = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    hazard_unit_if.slave hz
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]  stall_count,
    output logic [31:0]  kill_count
`endif
);
    // The writeback entry is never a forwarding source (regfile is write-through),
    // so only stages 1..DEPTH-1 are tracked.
    localparam int NT = DEPTH - 1;

    logic [NT:1]   p_valid;
    logic [NT:1]   p_we;
    logic [NT:1]   p_ld;
    logic [4:0]    p_rd [1:NT];
    logic [2:0]    kill_cnt;
    logic [FW-1:0] sel_a;
    logic [FW-1:0] sel_b;
    logic [FW-1:0] fwd_a_q;
    logic [FW-1:0] fwd_b_q;
    logic          lu_a;
    logic          lu_b;
    logic          kill;
    logic          stall;
    logic          advance;

    // Walk oldest to youngest so the youngest matching producer overwrites.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        lu_a  = 1'b0;
        lu_b  = 1'b0;
        for (int k = NT; k >= 1; k--) begin
            if (p_valid[k] && p_we[k] && (p_rd[k] != 5'd0)) begin
                if (hz.dec_uses_rs1 && (p_rd[k] == hz.dec_rs1)) begin
                    sel_a = FW'(k + 1);
                    lu_a  = p_ld[k] && ((k + 1) < LOAD_STAGE);
                end
                if (hz.dec_uses_rs2 && (p_rd[k] == hz.dec_rs2)) begin
                    sel_b = FW'(k + 1);
                    lu_b  = p_ld[k] && ((k + 1) < LOAD_STAGE);
                end
            end
        end
    end

    assign kill    = hz.redirect | (kill_cnt != 3'd0);
    assign stall   = hz.dec_valid & (lu_a | lu_b) & ~kill;
    assign advance = hz.dec_valid & ~stall & ~kill;

    assign hz.stall     = stall;
    assign hz.inst_kill = kill;
    assign hz.fwd_a     = fwd_a_q;
    assign hz.fwd_b     = fwd_b_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid  <= '0;
            kill_cnt <= 3'd0;
            fwd_a_q  <= '0;
            fwd_b_q  <= '0;
        end else begin
            p_valid[1] <= advance;
            for (int k = NT; k >= 2; k--) begin
                p_valid[k] <= p_valid[k-1];
            end
            if (hz.redirect) begin
                kill_cnt <= 3'(BR_KILL);
            end else if (kill_cnt != 3'd0) begin
                kill_cnt <= kill_cnt - 3'd1;
            end
            fwd_a_q <= advance ? sel_a : '0;
            fwd_b_q <= advance ? sel_b : '0;
        end
    end

    // Payload fields are qualified by p_valid, so they need no reset.
    always_ff @(posedge clk) begin
        p_rd[1] <= hz.dec_rd;
        p_we[1] <= hz.dec_rf_we;
        p_ld[1] <= hz.dec_is_load;
        for (int k = NT; k >= 2; k--) begin
            p_rd[k] <= p_rd[k-1];
            p_we[k] <= p_we[k-1];
            p_ld[k] <= p_ld[k-1];
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count <= 32'd0;
            kill_count  <= 32'd0;
        end else begin
            if (stall) stall_count <= stall_count + 32'd1;
            if (kill)  kill_count  <= kill_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_hazard_unit.sv
// tb/tb_hazard_unit.sv - directed vector bench for hazard_unit (DEPTH=3, LOAD_STAGE=3, BR_KILL=2)
module tb_hazard_unit;
    localparam int DEPTH      = 3;
    localparam int LOAD_STAGE = 3;
    localparam int BR_KILL    = 2;
    localparam int FW         = 2;

    typedef struct packed {
        logic       rst;
        logic       v;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       we;
        logic       ld;
        logic       redir;
        logic       chk;
        logic       es;
        logic       ek;
        logic [1:0] fa;
        logic [1:0] fb;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[$];
    vec_t t;

    always #5 clk = ~clk;

    hazard_unit_if #(.FW(FW)) hz();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_count;
    logic [31:0] kill_count;
`endif

    hazard_unit #(
        .DEPTH(DEPTH), .LOAD_STAGE(LOAD_STAGE), .BR_KILL(BR_KILL), .FW(FW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
`ifdef HAZARD_PERF_EN
        ,
        .stall_count(stall_count),
        .kill_count(kill_count)
`endif
    );

    function automatic vec_t mk(int v, int rs1, int u1, int rs2, int u2, int rd, int we, int ld,
                                int redir, int es, int ek, int fa, int fb);
        vec_t r;
        r.rst = 1'b0;  r.v = 1'(v);
        r.rs1 = 5'(rs1); r.u1 = 1'(u1); r.rs2 = 5'(rs2); r.u2 = 1'(u2);
        r.rd = 5'(rd); r.we = 1'(we); r.ld = 1'(ld); r.redir = 1'(redir);
        r.chk = 1'b1; r.es = 1'(es); r.ek = 1'(ek); r.fa = 2'(fa); r.fb = 2'(fb);
        return r;
    endfunction

    function automatic vec_t nop(int ek, int fa, int fb);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ek, fa, fb);
    endfunction

    // Drive one decode cycle, compare mid-cycle, return just after the next edge.
    task automatic apply(input vec_t x, input string name);
        reset           = x.rst;
        hz.dec_valid    = x.v;
        hz.dec_rs1      = x.rs1;
        hz.dec_uses_rs1 = x.u1;
        hz.dec_rs2      = x.rs2;
        hz.dec_uses_rs2 = x.u2;
        hz.dec_rd       = x.rd;
        hz.dec_rf_we    = x.we;
        hz.dec_is_load  = x.ld;
        hz.redirect     = x.redir;
        @(negedge clk);
        if (x.chk) begin
            n_vec++;
            if (hz.stall !== x.es || hz.inst_kill !== x.ek || hz.fwd_a !== x.fa || hz.fwd_b !== x.fb) begin
                n_bad++;
                $display("FAIL %s: stall/kill/fwd_a/fwd_b got %b/%b/%0d/%0d want %b/%b/%0d/%0d",
                         name, hz.stall, hz.inst_kill, hz.fwd_a, hz.fwd_b, x.es, x.ek, x.fa, x.fb);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        hz.dec_valid = 0; hz.dec_rs1 = 0; hz.dec_rs2 = 0; hz.dec_uses_rs1 = 0; hz.dec_uses_rs2 = 0;
        hz.dec_rd = 0; hz.dec_rf_we = 0; hz.dec_is_load = 0; hz.redirect = 0;
        repeat (2) @(posedge clk);
        #1;

        // reset state, still in reset
        t = nop(0, 0, 0); t.rst = 1'b1; tbl.push_back(t);
        tbl.push_back(nop(0, 0, 0));
        // forward from stage 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 5, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 5, 1, 5, 1, 6, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(nop(0, 2, 2));
        tbl.push_back(nop(0, 0, 0));
        // forward from stage 3; operand not used; writeback stage not forwarded
        tbl.push_back(mk(1, 0, 0, 0, 0, 10, 1, 0, 0,  0, 0, 0, 0));
        tbl.push_back(nop(0, 0, 0));
        tbl.push_back(mk(1, 10, 1, 10, 0, 11, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(1, 10, 1, 0, 0, 0, 0, 0, 0,  0, 0, 3, 0));
        tbl.push_back(nop(0, 0, 0));
        tbl.push_back(nop(0, 0, 0));
        // two producers of x9: youngest wins
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 9, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 1, 9, 1, 0, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(nop(0, 2, 2));
        // x0 is never a producer
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 0, 1, 12, 0, 0, 0,  0, 0, 0, 0));
        tbl.push_back(nop(0, 0, 0));
        // load-use: one stall cycle, then forward from stage 3
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 0,   1, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 1, 8, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(nop(0, 3, 0));
        tbl.push_back(nop(0, 0, 0));
        // redirect: kill for T..T+2, killed instructions become bubbles
        tbl.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 1,  0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 0, 13, 1, 0, 0,  0, 1, 0, 0));
        tbl.push_back(mk(1, 13, 1, 0, 0, 14, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(nop(0, 0, 0));
        // redirect over a load-use stall, second redirect extends kill
        tbl.push_back(mk(1, 0, 0, 0, 0, 7, 1, 1, 0,   0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 1,   0, 1, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 1,   0, 1, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0,   0, 1, 0, 0));
        tbl.push_back(mk(1, 7, 1, 0, 0, 8, 1, 0, 0,   0, 0, 0, 0));
        tbl.push_back(nop(0, 0, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i], $sformatf("tbl%0d", i));
        end

`ifdef HAZARD_PERF_EN
        n_vec++;
        if (stall_count !== 32'd1 || kill_count !== 32'd7) begin
            n_bad++;
            $display("FAIL perf_counts: got %0d/%0d want 1/7", stall_count, kill_count);
        end
`endif

        // reset during a load-use stall
        t = mk(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0, 0, 0); t.chk = 1'b0; apply(t, "rs_lw");
        apply(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 1, 0, 0, 0), "rs_stall");
        t = mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0); t.rst = 1'b1; t.chk = 1'b0; apply(t, "rs_rst");
        apply(mk(1, 7, 1, 0, 0, 8, 1, 0, 0, 0, 0, 0, 0), "rs_after");

        // reset with nonzero forwards and a coincident redirect
        t = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 0); t.chk = 1'b0; apply(t, "rf_prod");
        t = mk(1, 5, 1, 5, 1, 6, 1, 0, 0, 0, 0, 0, 0); t.chk = 1'b0; apply(t, "rf_cons");
        t = nop(1, 2, 2); t.rst = 1'b1; t.redir = 1'b1; apply(t, "rf_rst_redir");
        apply(nop(0, 0, 0), "rf_after");

        // reset mid-kill
        t = nop(1, 0, 0); t.redir = 1'b1; apply(t, "rk_redir");
        t = nop(1, 0, 0); t.rst = 1'b1; apply(t, "rk_rst");
        apply(nop(0, 0, 0), "rk_after");

`ifdef HAZARD_PERF_EN
        n_vec++;
        if (stall_count !== 32'd0 || kill_count !== 32'd0) begin
            n_bad++;
            $display("FAIL perf_reset: got %0d/%0d want 0/0", stall_count, kill_count);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
